// File: rtl/mem_pkg.sv
// Shared types and constants for the data-RAM access front end.
// The RW_* values match the RAM's read/write pin polarity.
package mem_pkg;

  localparam int MEM_WORDS_DEFAULT = 512;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } mau_state_t;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store front end for the data RAM: range-checks the
// word address, strobes the RAM, waits out read latency and returns a response.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int MEM_WORDS = MEM_WORDS_DEFAULT,
  parameter int READ_LAT  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        ram_en,
  output logic        ram_rw,
  output logic [15:0] ram_addr,
  output logic [15:0] ram_a,
  input  logic [15:0] ram_q,
  output logic [7:0]  err_count
);

  localparam logic [2:0] LAT_INIT = 3'(READ_LAT - 1);

  mau_state_t  state_q, state_d;
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [7:0]  err_count_q, err_count_d;
  logic        addr_fault;

  // Widened compare so a MEM_WORDS of 65536 would still behave correctly.
  assign addr_fault = ({1'b0, req_addr} >= 17'(MEM_WORDS));

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    err_count_d = err_count_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rdata_d = 16'h0000;
          err_d   = addr_fault;
          if (addr_fault) begin
            state_d = RESP;
            if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d = RESP;
        end else begin
          state_d = WAIT;
          cnt_d   = LAT_INIT;
        end
      end
      WAIT: begin
        if (cnt_q == 3'd0) begin
          rdata_d = ram_q;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      addr_q      <= 16'h0000;
      wdata_q     <= 16'h0000;
      cnt_q       <= 3'd0;
      rdata_q     <= 16'h0000;
      err_q       <= 1'b0;
      err_count_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
    end
  end

  // RAM pins are decoded from state so the strobe drops the cycle reset is seen.
  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign ram_en    = (state_q == ISSUE);
  assign ram_rw    = ((state_q == ISSUE) && we_q) ? RW_WRITE : RW_READ;
  assign ram_addr  = addr_q;
  assign ram_a     = wdata_q;
  assign err_count = err_count_q;

endmodule
